// File: rtl/stream_intf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_intf_pkg : shared constants and types for the PEA output streams
// Revision: 1.0
// ---------------------------------------------------------------------------
package stream_intf_pkg;

   localparam int N_PEA_DOUT_PER_OUT_STREAM     = 4;
   localparam int LOG_N_PEA_DOUT_PER_OUT_STREAM = 2;
   localparam int STREAM_OUT_FIFO_DEPTH         = 4;
   localparam int STREAM_LEN_W                  = 16;

   typedef enum logic [1:0] {
      SO_IDLE   = 2'd0,
      SO_STREAM = 2'd1,
      SO_DRAIN  = 2'd2,
      SO_DONE   = 2'd3
   } stream_out_state_e;

endpackage
`default_nettype wire

// File: rtl/stream_out_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_out_fifo : small synchronous FIFO with flush, head shown when non-empty
// Revision: 1.0
// ---------------------------------------------------------------------------
module stream_out_fifo
   import stream_intf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = STREAM_OUT_FIFO_DEPTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              do_push;
   logic              do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule
`default_nettype wire

// File: rtl/stream_out_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_out_ctrl : moves len words from one selected PEA output to a DMA channel
// Revision: 1.0
// ---------------------------------------------------------------------------
module stream_out_ctrl
   import stream_intf_pkg::*;
#(
   parameter int N_PEA_DOUT = N_PEA_DOUT_PER_OUT_STREAM,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = STREAM_OUT_FIFO_DEPTH
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     start_i,
   input  logic                                     abort_i,
   input  logic [STREAM_LEN_W-1:0]                  len_i,
   input  logic [LOG_N_PEA_DOUT_PER_OUT_STREAM-1:0] sel_i,
   input  logic [N_PEA_DOUT-1:0][DATA_W-1:0]        pea_dout_i,
   input  logic [N_PEA_DOUT-1:0]                    pea_dout_valid_i,
   output logic [N_PEA_DOUT-1:0]                    pea_dout_ready_o,
   output logic [DATA_W-1:0]                        dma_data_o,
   output logic                                     dma_valid_o,
   input  logic                                     dma_ready_i,
   output logic                                     busy_o,
   output logic                                     done_o
);

   stream_out_state_e                        state_q, state_d;
   logic [STREAM_LEN_W-1:0]                  len_q, len_d;
   logic [LOG_N_PEA_DOUT_PER_OUT_STREAM-1:0] sel_q, sel_d;
   logic [STREAM_LEN_W-1:0]                  acc_cnt_q, acc_cnt_d;
   logic [STREAM_LEN_W-1:0]                  snd_cnt_q, snd_cnt_d;

   logic fifo_full;
   logic fifo_empty;
   logic can_accept;
   logic push;
   logic pop;

   assign can_accept  = (state_q == SO_STREAM) && !fifo_full && (acc_cnt_q < len_q);
   assign push        = can_accept && pea_dout_valid_i[sel_q];
   assign dma_valid_o = !fifo_empty;
   assign pop         = dma_valid_o && dma_ready_i;

   for (genvar k = 0; k < N_PEA_DOUT; k++) begin : g_ready
      assign pea_dout_ready_o[k] = can_accept && (int'(sel_q) == k);
   end

   stream_out_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (abort_i),
      .push_i  (push),
      .data_i  (pea_dout_i[sel_q]),
      .pop_i   (pop),
      .data_o  (dma_data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      sel_d     = sel_q;
      acc_cnt_d = acc_cnt_q + {{(STREAM_LEN_W-1){1'b0}}, push};
      snd_cnt_d = snd_cnt_q + {{(STREAM_LEN_W-1){1'b0}}, pop};
      busy_o    = 1'b0;
      done_o    = 1'b0;

      case (state_q)
         SO_IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  len_d     = len_i;
                  sel_d     = sel_i;
                  acc_cnt_d = '0;
                  snd_cnt_d = '0;
                  state_d   = SO_STREAM;
               end else begin
                  state_d   = SO_DONE;
               end
            end
         end
         SO_STREAM: begin
            busy_o = 1'b1;
            if (acc_cnt_q == len_q) begin
               state_d = SO_DRAIN;
            end
         end
         SO_DRAIN: begin
            busy_o = 1'b1;
            // Counting the pop in flight lets done follow the last word by one cycle.
            if (snd_cnt_d == len_q) begin
               state_d = SO_DONE;
            end
         end
         SO_DONE: begin
            done_o  = 1'b1;
            state_d = SO_IDLE;
         end
         default: begin
            state_d = SO_IDLE;
         end
      endcase

      if (abort_i) begin
         state_d   = SO_IDLE;
         acc_cnt_d = '0;
         snd_cnt_d = '0;
         done_o    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= SO_IDLE;
         len_q     <= '0;
         sel_q     <= '0;
         acc_cnt_q <= '0;
         snd_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         sel_q     <= sel_d;
         acc_cnt_q <= acc_cnt_d;
         snd_cnt_q <= snd_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stream_out_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stream_out_ctrl : scoreboard bench for stream_out_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_stream_out_ctrl;

   localparam int N  = 4;
   localparam int DW = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 abort;
   logic [15:0]          len;
   logic [1:0]           sel;
   logic [N-1:0][DW-1:0] pea_dout;
   logic [N-1:0]         pea_valid;
   logic [N-1:0]         pea_ready;
   logic [DW-1:0]        dma_data;
   logic                 dma_valid;
   logic                 dma_ready;
   logic                 busy;
   logic                 done;

   logic [DW-1:0] sb[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            pushes, pops, dones;
   int            last_pop_cyc, done_cyc;
   int            exp_sel;
   bit            stray, activity;
   logic [N-1:0]  hs;

   stream_out_ctrl #(.N_PEA_DOUT(N), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (start),
      .abort_i          (abort),
      .len_i            (len),
      .sel_i            (sel),
      .pea_dout_i       (pea_dout),
      .pea_dout_valid_i (pea_valid),
      .pea_dout_ready_o (pea_ready),
      .dma_data_o       (dma_data),
      .dma_valid_o      (dma_valid),
      .dma_ready_i      (dma_ready),
      .busy_o           (busy),
      .done_o           (done)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: pops are checked against the queue, pushes enqueue the word driven.
   initial begin
      hs = '0;
      forever begin
         @(negedge clk);
         if (dma_valid && dma_ready) begin
            pops++;
            last_pop_cyc = cyc;
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else                chk("dma_data", dma_data, sb.pop_front());
         end
         for (int k = 0; k < N; k++) begin
            if (pea_valid[k] && pea_ready[k]) begin
               sb.push_back(pea_dout[k]);
               pushes++;
               hs[k] = 1'b1;
            end
            if (pea_ready[k] && k != exp_sel) stray = 1'b1;
         end
         if (pea_ready != '0 || dma_valid) activity = 1'b1;
         if (done) begin
            dones++;
            done_cyc = cyc;
         end
      end
   end

   // Each source advances its word after every accepted handshake.
   initial forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         if (hs[k]) pea_dout[k] = pea_dout[k] + 32'd1;
      end
      hs = '0;
   end

   task automatic clear_stats();
      pushes = 0; pops = 0; dones = 0;
      stray = 1'b0; activity = 1'b0;
      last_pop_cyc = 0; done_cyc = 0;
      sb.delete();
   endtask

   task automatic load_sources(input logic [31:0] base);
      for (int k = 0; k < N; k++) pea_dout[k] = base + 32'(k) * 32'h100;
   endtask

   task automatic start_xfer(input logic [15:0] l, input logic [1:0] s);
      exp_sel = int'(s);
      start = 1'b1; len = l; sel = s;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int maxc);
      int n;
      n = 0;
      while (dones < target && n < maxc) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= maxc) chk("done_timeout", 32'd0, 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_pushes(input int target, input int maxc);
      int n;
      n = 0;
      while (pushes < target && n < maxc) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= maxc) chk("push_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0; sel = '0;
      pea_valid = '0; dma_ready = 1'b0; exp_sel = 0;
      load_sources(32'h10);
      clear_stats();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(pea_ready), 32'd0);
      chk("rst_valid", 32'(dma_valid), 32'd0);
      chk("rst_data",  dma_data, 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic transfer
      clear_stats(); load_sources(32'h10);
      pea_valid = '1; dma_ready = 1'b1;
      start_xfer(16'd4, 2'd0);
      chk("basic_busy", 32'(busy), 32'd1);
      wait_done(1, 60);
      chk("basic_pops", 32'(pops), 32'd4);
      chk("basic_dones", 32'(dones), 32'd1);
      chk("basic_done_lat", 32'((done_cyc - last_pop_cyc >= 1) && (done_cyc - last_pop_cyc <= 2)), 32'd1);
      chk("basic_busy_end", 32'(busy), 32'd0);
      chk("basic_sb_empty", 32'(sb.size()), 32'd0);

      // Backpressure
      clear_stats(); load_sources(32'h200);
      dma_ready = 1'b0;
      start_xfer(16'd8, 2'd0);
      repeat (10) @(posedge clk);
      #1;
      chk("bp_pushes_full", 32'(pushes), 32'd4);
      chk("bp_ready_low", 32'(pea_ready), 32'd0);
      chk("bp_valid", 32'(dma_valid), 32'd1);
      dma_ready = 1'b1;
      wait_done(1, 80);
      chk("bp_pops", 32'(pops), 32'd8);
      chk("bp_dones", 32'(dones), 32'd1);
      chk("bp_done_after_last", 32'(done_cyc - last_pop_cyc), 32'd1);

      // Zero length
      clear_stats();
      start_xfer(16'd0, 2'd0);
      chk("zl_done", 32'(done), 32'd1);
      @(posedge clk); #1;
      chk("zl_done_off", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("zl_dones", 32'(dones), 32'd1);
      chk("zl_activity", 32'(activity), 32'd0);

      // Selection
      clear_stats(); load_sources(32'h1000);
      start_xfer(16'd6, 2'd2);
      wait_done(1, 80);
      chk("sel_stray", 32'(stray), 32'd0);
      chk("sel_pops", 32'(pops), 32'd6);
      chk("sel_src2_adv", pea_dout[2], 32'h1206);

      // Abort mid-stream, then the same using reset
      for (int pass = 0; pass < 2; pass++) begin
         clear_stats(); load_sources(32'h3000);
         dma_ready = 1'b0;
         start_xfer(16'd8, 2'd1);
         wait_pushes(2, 20);
         if (pass == 0) abort = 1'b1;
         else           rst = 1'b1;
         @(posedge clk); #1;
         abort = 1'b0; rst = 1'b0;
         sb.delete();
         chk(pass == 0 ? "abort_valid" : "rstx_valid", 32'(dma_valid), 32'd0);
         chk(pass == 0 ? "abort_busy"  : "rstx_busy",  32'(busy), 32'd0);
         chk(pass == 0 ? "abort_ready" : "rstx_ready", 32'(pea_ready), 32'd0);
         chk(pass == 0 ? "abort_done"  : "rstx_done",  32'(done), 32'd0);
         dma_ready = 1'b1;
         repeat (4) @(posedge clk);
         #1;
         chk(pass == 0 ? "abort_no_pops" : "rstx_no_pops", 32'(pops), 32'd0);
         chk(pass == 0 ? "abort_dones"   : "rstx_dones",   32'(dones), 32'd0);
      end

      // Start pulsed during DRAIN is ignored
      clear_stats(); load_sources(32'h40);
      dma_ready = 1'b1;
      start_xfer(16'd5, 2'd0);
      wait_pushes(5, 30);
      dma_ready = 1'b0;
      @(posedge clk); #1;
      chk("ign_busy_drain", 32'(busy), 32'd1);
      start = 1'b1; len = 16'd3; sel = 2'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      dma_ready = 1'b1;
      wait_done(1, 40);
      repeat (5) @(posedge clk);
      #1;
      chk("ign_pops", 32'(pops), 32'd5);
      chk("ign_dones", 32'(dones), 32'd1);
      chk("ign_pushes", 32'(pushes), 32'd5);
      chk("ign_busy_end", 32'(busy), 32'd0);
      chk("ign_stray", 32'(stray), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
